// File: rtl/stopwatch_pkg.sv
// Shared constants and command-priority encoding for the stopwatch.
// Latency: none (types/functions only).
// Backpressure: n/a.
package stopwatch_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_LAP_DEPTH = 4;

    // Exactly one command acts per cycle; this is its encoding.
    typedef enum logic [2:0] {
        RESET,
        LOAD,
        START,
        STOP,
        TICK,
        IDLE
    } cmd_e;

    // Priority resolution: do_reset > do_load > do_start > do_stop > do_tick.
    function automatic cmd_e decode_cmd(
        input logic do_reset,
        input logic do_load,
        input logic do_start,
        input logic do_stop,
        input logic do_tick
    );
        if (do_reset)      return RESET;
        else if (do_load)  return LOAD;
        else if (do_start) return START;
        else if (do_stop)  return STOP;
        else if (do_tick)  return TICK;
        else               return IDLE;
    endfunction

endpackage

// File: rtl/lap_fifo.sv
// Lap capture FIFO, first-word fall-through, LAP_DEPTH entries of WIDTH bits.
// Latency: push visible at head/count one cycle after the push edge.
// Backpressure: push when full is refused unless a pop completes in the same cycle.
// Ports: clk/rst; flush_i empties; push_i/push_dat_i/full_o; pop_i/valid_o/head_dat_o; count_o.
module lap_fifo
    import stopwatch_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LAP_DEPTH  = DEF_LAP_DEPTH,
    localparam int AW        = $clog2(LAP_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] head_dat_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [LAP_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_fire, pop_fire;

    assign full_o    = (count_q == (AW+1)'(LAP_DEPTH));
    assign valid_o   = (count_q != '0);
    assign pop_fire  = pop_i && valid_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_fire = push_i && (!full_o || pop_fire);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_fire) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_fire)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_fire && !pop_fire)      count_d = count_q + 1'b1;
            else if (pop_fire && !push_fire) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push_fire && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/stopwatch_lap.sv
// Up/down seconds stopwatch with done/wrap pulses and a lap-capture FIFO.
// Latency: commands sampled at an edge show on the registered outputs after that edge.
// Backpressure: lap reads use lap_valid/lap_ready; laps pushed while full are dropped and flagged.
// Ports: clk/rst; do_* commands with in_* load values; out_* state and pulses;
//        lap_valid/lap_ready/lap_seconds/lap_count/lap_overflow lap read side.
module stopwatch_lap
    import stopwatch_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int LAP_DEPTH = DEF_LAP_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         do_reset,
    input  logic                         do_load,
    input  logic [WIDTH-1:0]             in_seconds,
    input  logic                         in_running,
    input  logic                         in_down,
    input  logic                         do_start,
    input  logic                         do_stop,
    input  logic                         do_tick,
    input  logic                         do_lap,
    output logic [WIDTH-1:0]             out_seconds,
    output logic                         out_running,
    output logic                         out_down,
    output logic                         out_done,
    output logic                         out_wrap,
    output logic                         lap_valid,
    input  logic                         lap_ready,
    output logic [WIDTH-1:0]             lap_seconds,
    output logic [$clog2(LAP_DEPTH):0]   lap_count,
    output logic                         lap_overflow
);

    cmd_e             cmd;
    logic [WIDTH-1:0] sec_q, sec_d;
    logic             run_q, run_d;
    logic             down_q, down_d;
    logic             done_q, done_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             lap_push, lap_full, lap_drop;

    assign cmd = decode_cmd(do_reset, do_load, do_start, do_stop, do_tick);

    // Lap captures the count visible this cycle; only a reset discards it.
    assign lap_push = do_lap && (cmd != RESET);
    assign lap_drop = lap_push && lap_full && !(lap_ready && lap_valid);

    always_comb begin
        sec_d  = sec_q;
        run_d  = run_q;
        down_d = down_q;
        done_d = 1'b0;
        wrap_d = 1'b0;
        ovf_d  = ovf_q || lap_drop;
        unique case (cmd)
            RESET: begin
                sec_d = '0;
                run_d = 1'b0;
                ovf_d = 1'b0;
            end
            LOAD: begin
                sec_d  = in_seconds;
                run_d  = in_running;
                down_d = in_down;
            end
            START: run_d = 1'b1;
            STOP:  run_d = 1'b0;
            TICK: begin
                if (run_q) begin
                    if (!down_q) begin
                        sec_d  = sec_q + 1'b1;
                        wrap_d = &sec_q;
                    end else if (sec_q > WIDTH'(1)) begin
                        sec_d = sec_q - 1'b1;
                    end else begin
                        // Count of 1 or 0 both expire: start at 0 still yields done.
                        sec_d  = '0;
                        run_d  = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_q  <= '0;
            run_q  <= 1'b0;
            down_q <= 1'b0;
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sec_q  <= sec_d;
            run_q  <= run_d;
            down_q <= down_d;
            done_q <= done_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    lap_fifo #(
        .WIDTH     (WIDTH),
        .LAP_DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (cmd == RESET),
        .push_i     (lap_push),
        .push_dat_i (sec_q),
        .full_o     (lap_full),
        .pop_i      (lap_ready),
        .valid_o    (lap_valid),
        .head_dat_o (lap_seconds),
        .count_o    (lap_count)
    );

    assign out_seconds  = sec_q;
    assign out_running  = run_q;
    assign out_down     = down_q;
    assign out_done     = done_q;
    assign out_wrap     = wrap_q;
    assign lap_overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Directed-vector bench for stopwatch_lap with a scoreboard queue and a decoupled monitor.
// Latency: expectations describe outputs after the edge that sampled each vector.
// Backpressure: lap_ready is driven per vector.
module tb_stopwatch_lap;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int NV = 47;

    typedef struct {
        int rst; int rs; int ld; int isec; int irun; int idn;
        int st; int sp; int tk; int lap; int rdy; int n;
        int sec; int run; int dn; int done; int wrap; int lcnt; int lsec; int ovf;
    } vec_t;

    typedef struct {
        int   id;
        vec_t v;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         do_reset, do_load, in_running, in_down;
    logic         do_start, do_stop, do_tick, do_lap, lap_ready;
    logic [W-1:0] in_seconds;
    logic [W-1:0] out_seconds, lap_seconds;
    logic         out_running, out_down, out_done, out_wrap, lap_valid, lap_overflow;
    logic [2:0]   lap_count;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t exp_q [$];

    // rst rs ld isec irun idn st sp tk lap rdy n | sec run dn done wrap lcnt lsec ovf
    vec_t vecs [NV] = '{
        '{1,0,0, 0,0,0, 0,0,0,0,0, 1,   0,0,0,0,0, 0, 0,0},
        '{0,0,1, 5,1,1, 0,0,0,0,0, 1,   5,1,1,0,0, 0, 0,0},
        '{0,0,0, 0,0,0, 0,0,1,0,0, 1,   4,1,1,0,0, 0, 0,0},
        '{0,0,0, 0,0,0, 0,0,1,0,0, 1,   3,1,1,0,0, 0, 0,0},
        '{0,0,0, 0,0,0, 0,0,1,0,0, 1,   2,1,1,0,0, 0, 0,0},
        '{0,0,0, 0,0,0, 0,0,1,0,0, 1,   1,1,1,0,0, 0, 0,0},
        '{0,0,0, 0,0,0, 0,0,1,0,0, 1,   0,0,1,1,0, 0, 0,0},
        '{0,0,0, 0,0,0, 0,0,0,0,0, 1,   0,0,1,0,0, 0, 0,0},
        '{0,0,0, 0,0,0, 0,0,1,0,0, 1,   0,0,1,0,0, 0, 0,0},
        '{0,0,1,15,1,0, 0,0,0,0,0, 1,  15,1,0,0,0, 0, 0,0},
        '{0,0,0, 0,0,0, 0,0,1,0,0, 1,   0,1,0,0,1, 0, 0,0},
        '{0,0,0, 0,0,0, 0,0,0,0,0, 1,   0,1,0,0,0, 0, 0,0},
        '{0,0,0, 0,0,0, 0,0,1,0,0, 1,   1,1,0,0,0, 0, 0,0},
        '{0,0,1, 3,0,0, 0,0,0,0,0, 1,   3,0,0,0,0, 0, 0,0},
        '{0,0,0, 0,0,0, 0,0,1,0,0,10,   3,0,0,0,0, 0, 0,0},
        '{0,0,0, 0,0,0, 1,0,0,0,0, 1,   3,1,0,0,0, 0, 0,0},
        '{0,0,0, 0,0,0, 0,0,1,0,0, 1,   4,1,0,0,0, 0, 0,0},
        '{0,0,0, 0,0,0, 0,1,0,0,0, 1,   4,0,0,0,0, 0, 0,0},
        '{0,0,0, 0,0,0, 1,1,0,0,0, 1,   4,1,0,0,0, 0, 0,0},
        '{0,0,0, 0,0,0, 0,1,1,0,0, 1,   4,0,0,0,0, 0, 0,0},
        '{0,0,1, 7,0,0, 1,0,0,0,0, 1,   7,0,0,0,0, 0, 0,0},
        '{0,0,0, 0,0,0, 1,0,0,0,0, 1,   7,1,0,0,0, 0, 0,0},
        '{0,0,0, 0,0,0, 0,0,1,1,0, 1,   8,1,0,0,0, 1, 7,0},
        '{0,0,0, 0,0,0, 0,1,0,1,0, 1,   8,0,0,0,0, 2, 7,0},
        '{0,0,1, 2,0,0, 0,0,0,1,0, 1,   2,0,0,0,0, 3, 7,0},
        '{0,0,0, 0,0,0, 0,0,0,1,0, 1,   2,0,0,0,0, 4, 7,0},
        '{0,0,0, 0,0,0, 0,0,0,1,0, 1,   2,0,0,0,0, 4, 7,1},
        '{0,0,1,11,0,0, 0,0,0,0,0, 1,  11,0,0,0,0, 4, 7,1},
        '{0,0,0, 0,0,0, 0,0,0,1,1, 1,  11,0,0,0,0, 4, 8,1},
        '{0,0,0, 0,0,0, 0,0,0,0,1, 1,  11,0,0,0,0, 3, 8,1},
        '{0,0,0, 0,0,0, 0,0,0,0,1, 1,  11,0,0,0,0, 2, 2,1},
        '{0,0,0, 0,0,0, 0,0,0,0,1, 1,  11,0,0,0,0, 1,11,1},
        '{0,0,0, 0,0,0, 0,0,0,0,1, 1,  11,0,0,0,0, 0, 0,1},
        '{0,0,0, 0,0,0, 0,0,0,0,1, 1,  11,0,0,0,0, 0, 0,1},
        '{0,0,1, 9,0,1, 0,0,0,0,0, 1,   9,0,1,0,0, 0, 0,1},
        '{0,0,0, 0,0,0, 0,0,0,1,0, 1,   9,0,1,0,0, 1, 9,1},
        '{0,1,0, 0,0,0, 1,0,0,1,0, 1,   0,0,1,0,0, 0, 0,0},
        '{0,0,0, 0,0,0, 1,0,0,0,0, 1,   0,1,1,0,0, 0, 0,0},
        '{0,0,0, 0,0,0, 0,0,1,0,0, 1,   0,0,1,1,0, 0, 0,0},
        '{0,0,0, 0,0,0, 0,0,0,0,0, 1,   0,0,1,0,0, 0, 0,0},
        '{0,0,1, 6,1,1, 0,0,0,1,0, 1,   6,1,1,0,0, 1, 0,0},
        '{1,0,0, 0,0,0, 0,0,1,1,1, 1,   0,0,0,0,0, 0, 0,0},
        '{0,0,1, 5,1,0, 0,0,1,0,0, 1,   5,1,0,0,0, 0, 0,0},
        '{0,0,0, 0,0,0, 0,0,1,0,0, 1,   6,1,0,0,0, 0, 0,0},
        '{0,0,0, 0,0,0, 0,0,0,1,1, 1,   6,1,0,0,0, 1, 6,0},
        '{0,0,0, 0,0,0, 0,0,1,0,0, 1,   7,1,0,0,0, 1, 6,0},
        '{0,0,0, 0,0,0, 0,0,0,1,1, 1,   7,1,0,0,0, 1, 7,0}
    };

    stopwatch_lap #(
        .WIDTH     (W),
        .LAP_DEPTH (D)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .do_reset     (do_reset),
        .do_load      (do_load),
        .in_seconds   (in_seconds),
        .in_running   (in_running),
        .in_down      (in_down),
        .do_start     (do_start),
        .do_stop      (do_stop),
        .do_tick      (do_tick),
        .do_lap       (do_lap),
        .out_seconds  (out_seconds),
        .out_running  (out_running),
        .out_down     (out_down),
        .out_done     (out_done),
        .out_wrap     (out_wrap),
        .lap_valid    (lap_valid),
        .lap_ready    (lap_ready),
        .lap_seconds  (lap_seconds),
        .lap_count    (lap_count),
        .lap_overflow (lap_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input int exp);
        n_chk++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s (vector %0d): got %0d, expected %0d", nm, id, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        rst        = (v.rst  != 0);
        do_reset   = (v.rs   != 0);
        do_load    = (v.ld   != 0);
        in_seconds = W'(v.isec);
        in_running = (v.irun != 0);
        in_down    = (v.idn  != 0);
        do_start   = (v.st   != 0);
        do_stop    = (v.sp   != 0);
        do_tick    = (v.tk   != 0);
        do_lap     = (v.lap  != 0);
        lap_ready  = (v.rdy  != 0);
    endtask

    // Monitor: outputs are registered, so every cycle presents a response;
    // compare it against the oldest expectation waiting in the scoreboard.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_seconds",  e.id, 32'(out_seconds),  e.v.sec);
            chk("out_running",  e.id, 32'(out_running),  e.v.run);
            chk("out_down",     e.id, 32'(out_down),     e.v.dn);
            chk("out_done",     e.id, 32'(out_done),     e.v.done);
            chk("out_wrap",     e.id, 32'(out_wrap),     e.v.wrap);
            chk("lap_count",    e.id, 32'(lap_count),    e.v.lcnt);
            chk("lap_valid",    e.id, 32'(lap_valid),    (e.v.lcnt != 0) ? 1 : 0);
            chk("lap_overflow", e.id, 32'(lap_overflow), e.v.ovf);
            if (e.v.lcnt != 0)
                chk("lap_seconds", e.id, 32'(lap_seconds), e.v.lsec);
        end
    end

    // Driver: apply a vector, let the edge sample it, then queue the expected response.
    initial begin
        vec_t idle;
        idle = '{0,0,0,0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0,0};
        apply(idle);
        for (int i = 0; i < NV; i++) begin
            for (int r = 0; r < vecs[i].n; r++) begin
                apply(vecs[i]);
                @(posedge clk);
                exp_q.push_back('{id: i, v: vecs[i]});
                #1;
            end
        end
        apply(idle);
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
